// File: rtl/serial_link_dir_switch.sv
// Direction-switch controller for the Kerberos serial-link wrapper.
// Counts in-flight AW/AR/W traffic. On a direction change it closes the
// AW/AR path and waits until every counter reaches zero. It then updates
// direction_select_o and holds the path closed for a settle window before
// reopening it.
module serial_link_dir_switch #(
    parameter int unsigned MaxOutstanding = 16,
    parameter int unsigned SettleCycles   = 8,
    parameter logic [1:0]  ResetDir       = 2'b00
) (
    input  logic       clk_i,
    input  logic       rst_i,
    // direction-change request
    input  logic       dir_req_valid_i,
    input  logic [1:0] dir_req_i,
    output logic       dir_req_ready_o,
    output logic [1:0] direction_select_o,
    output logic       busy_o,
    output logic       err_o,
    // AW channel, split into upstream and downstream sides
    input  logic       slv_aw_valid_i,
    output logic       slv_aw_ready_o,
    output logic       mst_aw_valid_o,
    input  logic       mst_aw_ready_i,
    // AR channel
    input  logic       slv_ar_valid_i,
    output logic       slv_ar_ready_o,
    output logic       mst_ar_valid_o,
    input  logic       mst_ar_ready_i,
    // W channel
    input  logic       slv_w_valid_i,
    output logic       slv_w_ready_o,
    output logic       mst_w_valid_o,
    input  logic       mst_w_ready_i,
    input  logic       w_last_i,
    // observed response handshakes
    input  logic       b_valid_i,
    input  logic       b_ready_i,
    input  logic       r_valid_i,
    input  logic       r_ready_i,
    input  logic       r_last_i
);

    localparam int unsigned     CntW       = $clog2(MaxOutstanding + 1);
    localparam int unsigned     SetW       = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
    localparam logic [CntW-1:0] CntMax     = CntW'(MaxOutstanding);
    localparam logic [SetW-1:0] SettleLoad = SetW'(SettleCycles - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        SETTLE
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      dir_q, dir_d;
    logic [1:0]      target_q, target_d;
    logic [SetW-1:0] settle_q, settle_d;

    logic [CntW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CntW-1:0] rd_cnt_q, rd_cnt_d;
    logic [CntW-1:0] w_cnt_q, w_cnt_d;
    logic            wr_uf, rd_uf, w_uf;
    logic            err_q;

    logic open_aw, open_ar, open_w;
    logic aw_hs, ar_hs, w_last_hs, b_hs, r_last_hs;
    logic drain_done;

    // Next counter value plus an underflow flag in the MSB. A simultaneous
    // increment and decrement cancel out. A decrement at zero holds the
    // counter and reports underflow.
    function automatic logic [CntW:0] cnt_step(input logic [CntW-1:0] cnt,
                                               input logic            inc,
                                               input logic            dec);
        logic [CntW-1:0] nxt;
        logic            uf;
        nxt = cnt;
        uf  = 1'b0;
        case ({inc, dec})
            2'b10: nxt = (cnt == CntMax) ? cnt : cnt + 1'b1;
            2'b01: begin
                if (cnt == '0) uf  = 1'b1;
                else           nxt = cnt - 1'b1;
            end
            default: nxt = cnt;
        endcase
        return {uf, nxt};
    endfunction

    // Channel gates. W is never gated by state, because bursts of
    // already-accepted AWs must still complete during a drain.
    assign open_aw = (state_q == IDLE) && (wr_cnt_q < CntMax);
    assign open_ar = (state_q == IDLE) && (rd_cnt_q < CntMax);
    assign open_w  = (w_cnt_q != '0);

    assign mst_aw_valid_o = slv_aw_valid_i & open_aw;
    assign slv_aw_ready_o = mst_aw_ready_i & open_aw;
    assign mst_ar_valid_o = slv_ar_valid_i & open_ar;
    assign slv_ar_ready_o = mst_ar_ready_i & open_ar;
    assign mst_w_valid_o  = slv_w_valid_i  & open_w;
    assign slv_w_ready_o  = mst_w_ready_i  & open_w;

    assign aw_hs     = slv_aw_valid_i & slv_aw_ready_o;
    assign ar_hs     = slv_ar_valid_i & slv_ar_ready_o;
    assign w_last_hs = mst_w_valid_o & mst_w_ready_i & w_last_i;
    assign b_hs      = b_valid_i & b_ready_i;
    assign r_last_hs = r_valid_i & r_ready_i & r_last_i;

    assign drain_done = (wr_cnt_q == '0) && (rd_cnt_q == '0) && (w_cnt_q == '0);

    // Next outstanding-counter values for writes, reads and pending W bursts.
    always_comb begin
        {wr_uf, wr_cnt_d} = cnt_step(wr_cnt_q, aw_hs, b_hs);
        {rd_uf, rd_cnt_d} = cnt_step(rd_cnt_q, ar_hs, r_last_hs);
        {w_uf,  w_cnt_d}  = cnt_step(w_cnt_q,  aw_hs, w_last_hs);
    end

    // Outstanding counters and the sticky underflow flag.
    // NOTE: state is updated with non-blocking assignments only, so every flop
    // samples the values that existed before the edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            w_cnt_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            w_cnt_q  <= w_cnt_d;
            if (wr_uf || rd_uf || w_uf) err_q <= 1'b1;
        end
    end

    // FSM next state: accept requests in IDLE, wait for the drain, then count
    // down the settle window.
    // NOTE: every signal gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        state_d         = state_q;
        dir_d           = dir_q;
        target_d        = target_q;
        settle_d        = settle_q;
        dir_req_ready_o = 1'b0;
        busy_o          = 1'b1;
        unique case (state_q)
            IDLE: begin
                dir_req_ready_o = 1'b1;
                busy_o          = 1'b0;
                if (dir_req_valid_i && (dir_req_i != dir_q)) begin
                    target_d = dir_req_i;
                    state_d  = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    dir_d    = target_q;
                    settle_d = SettleLoad;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_q == '0) state_d  = IDLE;
                else                settle_d = settle_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, current direction, latched target and settle counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            dir_q    <= ResetDir;
            target_q <= ResetDir;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            target_q <= target_d;
            settle_q <= settle_d;
        end
    end

    assign direction_select_o = dir_q;
    assign err_o              = err_q;

endmodule
